// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling from a cycle-count
// baud timer, valid/ack holding register with framing and overrun flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          sync1_q, rxs_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          good_frame;
  logic          ack_eff;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    good_frame  = 1'b0;
    ack_eff     = rx_ack & rx_valid_q;

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs_q;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            good_frame = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        // Hold here so a line stuck low cannot retrigger a start bit.
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (ack_eff) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    // An ack in the same cycle retires the old byte, so no overrun.
    if (good_frame) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rxd;
      rxs_q       <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes, a negedge
// monitor pops and checks whenever a new byte is presented.
module tb_uart_rx;
  localparam int C = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  typedef struct { logic [7:0] data; logic ovr; } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fe_cnt  = 0;
  int last_valid_cyc = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] data_prev  = 8'h00;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(C);
    end
    rxd = stop;
    tick(C);
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic ovr);
    exp_t e;
    e.data = b;
    e.ovr  = ovr;
    exp_q.push_back(e);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  // Monitor: a new byte is a rising rx_valid or a data change while valid.
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid && (!valid_prev || rx_data != data_prev)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h with no expected entry", rx_data);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", {24'h0, rx_data}, {24'h0, e.data});
        check("overrun_at_byte", {31'h0, overrun}, {31'h0, e.ovr});
        check("busy_falls_with_valid", {31'h0, busy}, 32'h0);
        last_valid_cyc = cyc;
      end
    end
    if (frame_err) fe_cnt++;
    valid_prev = rx_valid;
    data_prev  = rx_data;
  end

  initial begin
    int bad;
    int start_cyc;
    int lat;

    // Reset
    tick(3);
    check("reset_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_data", {24'h0, rx_data}, 32'h0);
    check("reset_overrun", {31'h0, overrun}, 32'h0);
    reset = 1'b1;

    // Idle line for 1000 cycles
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (rx_valid || busy || frame_err) bad++;
    end
    check("idle_quiet", bad, 0);

    // Good frame 0xA5, latency, then ack
    expect_byte(8'hA5, 1'b0);
    start_cyc = cyc;
    send_byte(8'hA5, 1'b1);
    check("a5_valid", {31'h0, rx_valid}, 32'h1);
    lat = last_valid_cyc - start_cyc;
    n_tests++;
    if (lat < 150 || lat > 158) begin
      n_fail++;
      $display("FAIL a5_latency: got %0d cycles expected 150..158", lat);
    end
    tick(3);
    ack_pulse();
    check("a5_ack_clears_valid", {31'h0, rx_valid}, 32'h0);

    // Glitch shorter than half a bit
    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    tick(40);
    check("glitch_busy", {31'h0, busy}, 32'h0);
    check("glitch_valid", {31'h0, rx_valid}, 32'h0);
    check("glitch_frame_err", fe_cnt, 0);

    // Framing error with line held low, then recovery
    send_byte(8'h3C, 1'b0);
    tick(100);
    check("fe_one_pulse", fe_cnt, 1);
    check("fe_valid", {31'h0, rx_valid}, 32'h0);
    check("fe_busy_held", {31'h0, busy}, 32'h1);
    check("fe_data_kept", {24'h0, rx_data}, 32'hA5);
    rxd = 1'b1;
    tick(10);
    check("fe_busy_released", {31'h0, busy}, 32'h0);
    expect_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b1);
    tick(2);
    ack_pulse();

    // Back-to-back frames without ack -> overrun
    expect_byte(8'h11, 1'b0);
    send_byte(8'h11, 1'b1);
    expect_byte(8'h22, 1'b1);
    send_byte(8'h22, 1'b1);
    check("ovr_valid", {31'h0, rx_valid}, 32'h1);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    ack_pulse();
    check("ovr_ack_valid", {31'h0, rx_valid}, 32'h0);
    check("ovr_ack_flag", {31'h0, overrun}, 32'h0);
    tick(5);

    // Reset mid-frame with a byte held, then a clean frame
    expect_byte(8'h9A, 1'b0);
    send_byte(8'h9A, 1'b1);
    rxd = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      tick(C);
    end
    rxd = 1'b1;
    tick(C / 2);
    reset = 1'b0;
    rxd = 1'b1;
    tick(2);
    reset = 1'b1;
    check("midreset_valid", {31'h0, rx_valid}, 32'h0);
    check("midreset_data", {24'h0, rx_data}, 32'h0);
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_overrun", {31'h0, overrun}, 32'h0);
    check("midreset_frame_err", {31'h0, frame_err}, 32'h0);
    tick(3 * C);
    check("midreset_no_stray_fe", fe_cnt, 1);
    expect_byte(8'hF0, 1'b0);
    send_byte(8'hF0, 1'b1);
    check("f0_valid", {31'h0, rx_valid}, 32'h1);
    ack_pulse();
    tick(20);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
